// File: rtl/tcp_misc_pkg.sv
// Shared TCP slow-path types: the outbound header layout and the send-queue entry
// that carries a header together with its flow and IP addressing.
package tcp_misc_pkg;

  localparam int FLOWID_W  = 8;
  localparam int IP_ADDR_W = 32;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [7:0]  flags;
    logic [15:0] window;
  } tcp_pkt_hdr;

  typedef struct packed {
    tcp_pkt_hdr             pkt;
    logic [FLOWID_W-1:0]    flowid;
    logic [IP_ADDR_W-1:0]   src_ip;
    logic [IP_ADDR_W-1:0]   dst_ip;
  } slow_path_send_q_entry;

endpackage

// File: rtl/tcp_slow_path_send_q.sv
// Small FIFO of SYN-ACK headers from the rx datapath to the tx engine.
// A request for a flow that is already queued is coalesced and counted instead of stored.
module tcp_slow_path_send_q
  import tcp_misc_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 16,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int PTR_W = IDX_W + 1
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 slow_path_send_pkt_enqueue_val,
  input  tcp_pkt_hdr           slow_path_send_pkt_enqueue_pkt,
  input  logic [FLOWID_W-1:0]  slow_path_send_pkt_enqueue_flowid,
  input  logic [IP_ADDR_W-1:0] slow_path_send_pkt_enqueue_src_ip,
  input  logic [IP_ADDR_W-1:0] slow_path_send_pkt_enqueue_dst_ip,
  output logic                 slow_path_send_pkt_enqueue_rdy,

  output logic                 slow_path_send_pkt_dequeue_val,
  output tcp_pkt_hdr           slow_path_send_pkt_dequeue_pkt,
  output logic [FLOWID_W-1:0]  slow_path_send_pkt_dequeue_flowid,
  output logic [IP_ADDR_W-1:0] slow_path_send_pkt_dequeue_src_ip,
  output logic [IP_ADDR_W-1:0] slow_path_send_pkt_dequeue_dst_ip,
  input  logic                 slow_path_send_pkt_dequeue_rdy,

  output logic [PTR_W-1:0]     send_q_occupancy,
  output logic [CNT_W-1:0]     send_q_dup_drop_cnt
);

  slow_path_send_q_entry mem_q [DEPTH];
  slow_path_send_q_entry enq_entry;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             full, empty;
  logic             enq_hs, deq_hs, dup_hit, store;
  logic [DEPTH-1:0] slot_match;

  assign wr_idx = wr_ptr_q[IDX_W-1:0];
  assign rd_idx = rd_ptr_q[IDX_W-1:0];

  // Wrap bit distinguishes full from empty when the slot indices coincide.
  assign full  = (wr_idx == rd_idx) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign slow_path_send_pkt_enqueue_rdy = !full;
  assign slow_path_send_pkt_dequeue_val = !empty;

  assign slow_path_send_pkt_dequeue_pkt    = mem_q[rd_idx].pkt;
  assign slow_path_send_pkt_dequeue_flowid = mem_q[rd_idx].flowid;
  assign slow_path_send_pkt_dequeue_src_ip = mem_q[rd_idx].src_ip;
  assign slow_path_send_pkt_dequeue_dst_ip = mem_q[rd_idx].dst_ip;

  assign send_q_occupancy    = wr_ptr_q - rd_ptr_q;
  assign send_q_dup_drop_cnt = drop_cnt_q;

  assign enq_hs = slow_path_send_pkt_enqueue_val && !full;
  assign deq_hs = slow_path_send_pkt_dequeue_rdy && !empty;

  assign enq_entry.pkt    = slow_path_send_pkt_enqueue_pkt;
  assign enq_entry.flowid = slow_path_send_pkt_enqueue_flowid;
  assign enq_entry.src_ip = slow_path_send_pkt_enqueue_src_ip;
  assign enq_entry.dst_ip = slow_path_send_pkt_enqueue_dst_ip;

  // The head slot leaving this cycle no longer counts as a duplicate.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_match[i] = valid_q[i]
                   && (mem_q[i].flowid == slow_path_send_pkt_enqueue_flowid)
                   && !(deq_hs && (rd_idx == IDX_W'(i)));
    end
  end

  assign dup_hit = |slot_match;
  assign store   = enq_hs && !dup_hit;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    valid_d    = valid_q;
    drop_cnt_d = drop_cnt_q;
    if (deq_hs) begin
      rd_ptr_d         = rd_ptr_q + PTR_W'(1);
      valid_d[rd_idx]  = 1'b0;
    end
    if (store) begin
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      valid_d[wr_idx]  = 1'b1;
    end
    if (enq_hs && dup_hit && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      valid_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      valid_q    <= valid_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; valid_q and the pointers qualify it.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_q[wr_idx] <= enq_entry;
    end
  end

endmodule

// File: tb/tb_tcp_slow_path_send_q.sv
// Bench for tcp_slow_path_send_q: a queue-based reference model checked every cycle,
// plus directed fill, duplicate, head-exclusion, reset, saturation and wrap scenarios.
module tb_tcp_slow_path_send_q;
  import tcp_misc_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 enq_val;
  tcp_pkt_hdr           enq_pkt;
  logic [FLOWID_W-1:0]  enq_flowid;
  logic [IP_ADDR_W-1:0] enq_src, enq_dst;
  logic                 deq_rdy;

  logic                 enq_rdy, deq_val;
  tcp_pkt_hdr           deq_pkt;
  logic [FLOWID_W-1:0]  deq_flowid;
  logic [IP_ADDR_W-1:0] deq_src, deq_dst;
  logic [PTR_W-1:0]     occ;
  logic [15:0]          cnt;

  logic                 enq_rdy2, deq_val2;
  tcp_pkt_hdr           deq_pkt2;
  logic [FLOWID_W-1:0]  deq_flowid2;
  logic [IP_ADDR_W-1:0] deq_src2, deq_dst2;
  logic [PTR_W-1:0]     occ2;
  logic [1:0]           cnt2;

  tcp_slow_path_send_q #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .slow_path_send_pkt_enqueue_val(enq_val),
    .slow_path_send_pkt_enqueue_pkt(enq_pkt),
    .slow_path_send_pkt_enqueue_flowid(enq_flowid),
    .slow_path_send_pkt_enqueue_src_ip(enq_src),
    .slow_path_send_pkt_enqueue_dst_ip(enq_dst),
    .slow_path_send_pkt_enqueue_rdy(enq_rdy),
    .slow_path_send_pkt_dequeue_val(deq_val),
    .slow_path_send_pkt_dequeue_pkt(deq_pkt),
    .slow_path_send_pkt_dequeue_flowid(deq_flowid),
    .slow_path_send_pkt_dequeue_src_ip(deq_src),
    .slow_path_send_pkt_dequeue_dst_ip(deq_dst),
    .slow_path_send_pkt_dequeue_rdy(deq_rdy),
    .send_q_occupancy(occ),
    .send_q_dup_drop_cnt(cnt)
  );

  // Narrow-counter copy sharing the same stimulus, used for saturation.
  tcp_slow_path_send_q #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .slow_path_send_pkt_enqueue_val(enq_val),
    .slow_path_send_pkt_enqueue_pkt(enq_pkt),
    .slow_path_send_pkt_enqueue_flowid(enq_flowid),
    .slow_path_send_pkt_enqueue_src_ip(enq_src),
    .slow_path_send_pkt_enqueue_dst_ip(enq_dst),
    .slow_path_send_pkt_enqueue_rdy(enq_rdy2),
    .slow_path_send_pkt_dequeue_val(deq_val2),
    .slow_path_send_pkt_dequeue_pkt(deq_pkt2),
    .slow_path_send_pkt_dequeue_flowid(deq_flowid2),
    .slow_path_send_pkt_dequeue_src_ip(deq_src2),
    .slow_path_send_pkt_dequeue_dst_ip(deq_dst2),
    .slow_path_send_pkt_dequeue_rdy(deq_rdy),
    .send_q_occupancy(occ2),
    .send_q_dup_drop_cnt(cnt2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  slow_path_send_q_entry model_q[$];
  int                    model_cnt = 0;
  int                    popped[$];
  bit                    cmp_en = 1'b0;
  bit                    acc;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int c, input int m);
    return (c > m) ? m : c;
  endfunction

  function automatic tcp_pkt_hdr rand_hdr();
    tcp_pkt_hdr h;
    h.src_port = 16'($urandom);
    h.dst_port = 16'($urandom);
    h.seq_num  = $urandom;
    h.ack_num  = $urandom;
    h.flags    = 8'($urandom);
    h.window   = 16'($urandom);
    return h;
  endfunction

  // Drives one cycle of inputs, predicts the handshakes from the model, applies them at the edge.
  task automatic step(input bit v, input int fid, input bit dr, output bit accepted);
    slow_path_send_q_entry e;
    bit e_hs, d_hs, dup;
    e.pkt    = rand_hdr();
    e.flowid = FLOWID_W'(fid);
    e.src_ip = $urandom;
    e.dst_ip = $urandom;
    enq_val    = v;
    enq_pkt    = e.pkt;
    enq_flowid = e.flowid;
    enq_src    = e.src_ip;
    enq_dst    = e.dst_ip;
    deq_rdy    = dr;
    e_hs = v && (model_q.size() != DEPTH);
    d_hs = dr && (model_q.size() != 0);
    dup  = 1'b0;
    if (e_hs) begin
      for (int i = (d_hs ? 1 : 0); i < model_q.size(); i++) begin
        if (model_q[i].flowid == e.flowid) dup = 1'b1;
      end
    end
    @(posedge clk);
    if (d_hs) begin
      popped.push_back(int'(model_q[0].flowid));
      void'(model_q.pop_front());
    end
    if (e_hs) begin
      if (dup) model_cnt++;
      else     model_q.push_back(e);
    end
    accepted = e_hs && !dup;
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("enq_rdy", 128'(enq_rdy), 128'(model_q.size() != DEPTH));
      check("deq_val", 128'(deq_val), 128'(model_q.size() != 0));
      check("occupancy", 128'(occ), 128'(model_q.size()));
      check("dup_cnt", 128'(cnt), 128'(sat(model_cnt, 65535)));
      check("sat_enq_rdy", 128'(enq_rdy2), 128'(model_q.size() != DEPTH));
      check("sat_deq_val", 128'(deq_val2), 128'(model_q.size() != 0));
      check("sat_occupancy", 128'(occ2), 128'(model_q.size()));
      check("sat_dup_cnt", 128'(cnt2), 128'(sat(model_cnt, 3)));
      if (model_q.size() != 0) begin
        check("head_pkt", 128'(deq_pkt), 128'(model_q[0].pkt));
        check("head_flowid", 128'(deq_flowid), 128'(model_q[0].flowid));
        check("head_src_ip", 128'(deq_src), 128'(model_q[0].src_ip));
        check("head_dst_ip", 128'(deq_dst), 128'(model_q[0].dst_ip));
        check("sat_head_pkt", 128'(deq_pkt2), 128'(model_q[0].pkt));
        check("sat_head_flowid", 128'(deq_flowid2), 128'(model_q[0].flowid));
        check("sat_head_ips", {64'(deq_src2), 64'(deq_dst2)},
              {64'(model_q[0].src_ip), 64'(model_q[0].dst_ip)});
      end
    end
  end

  initial begin
    int next_fid;
    int psize;
    rst = 1'b0;
    enq_val = 1'b0; enq_pkt = '0; enq_flowid = '0; enq_src = '0; enq_dst = '0;
    deq_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_enq_rdy", 128'(enq_rdy), 128'(1));
    check("reset_deq_val", 128'(deq_val), 128'(0));
    check("reset_occ", 128'(occ), 128'(0));
    check("reset_cnt", 128'(cnt), 128'(0));
    #3 rst = 1'b1;
    @(posedge clk); #1;
    cmp_en = 1'b1;

    // Fill to DEPTH, then a blocked enqueue alongside a dequeue.
    for (int f = 1; f <= 4; f++) step(1'b1, f, 1'b0, acc);
    check("fill_enq_rdy", 128'(enq_rdy), 128'(0));
    check("fill_occ", 128'(occ), 128'(4));
    check("fill_head", 128'(deq_flowid), 128'(1));
    step(1'b1, 5, 1'b1, acc);
    check("full_enq_blocked", 128'(acc), 128'(0));
    check("full_occ_after", 128'(occ), 128'(3));
    repeat (3) step(1'b0, 0, 1'b1, acc);
    check("fill_order", {32'(popped[0]), 32'(popped[1]), 32'(popped[2]), 32'(popped[3])},
          {32'd1, 32'd2, 32'd3, 32'd4});

    // Duplicate coalescing.
    step(1'b1, 5, 1'b0, acc);
    step(1'b1, 5, 1'b0, acc);
    check("dup_occ", 128'(occ), 128'(1));
    check("dup_cnt_lit", 128'(cnt), 128'(1));
    psize = popped.size();
    step(1'b0, 0, 1'b1, acc);
    step(1'b0, 0, 1'b1, acc);
    check("dup_single_deq", 128'(popped.size() - psize), 128'(1));
    check("dup_deq_fid", 128'(popped[popped.size()-1]), 128'(5));

    // Head exclusion: leaving head does not count as a duplicate.
    step(1'b1, 7, 1'b0, acc);
    step(1'b1, 7, 1'b1, acc);
    check("hx_occ", 128'(occ), 128'(1));
    check("hx_cnt", 128'(cnt), 128'(1));
    check("hx_head", 128'(deq_flowid), 128'(7));
    step(1'b0, 0, 1'b1, acc);

    // Asynchronous reset mid-operation.
    for (int f = 10; f <= 12; f++) step(1'b1, f, 1'b0, acc);
    check("pre_rst_occ", 128'(occ), 128'(3));
    enq_val = 1'b0; deq_rdy = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_deq_val", 128'(deq_val), 128'(0));
    check("rst_occ", 128'(occ), 128'(0));
    check("rst_enq_rdy", 128'(enq_rdy), 128'(1));
    check("rst_cnt", 128'(cnt), 128'(0));
    model_q.delete();
    model_cnt = 0;
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    popped.delete();
    step(1'b1, 9, 1'b0, acc);
    step(1'b0, 0, 1'b1, acc);
    check("rst_first_out", 128'(popped.size() > 0 ? popped[0] : 255), 128'(9));

    // Saturation on the 2-bit counter.
    step(1'b1, 20, 1'b0, acc);
    repeat (5) step(1'b1, 20, 1'b0, acc);
    check("sat_cnt_lit", 128'(cnt2), 128'(3));
    check("wide_cnt_lit", 128'(cnt), 128'(5));
    step(1'b0, 0, 1'b1, acc);

    // Wrap: flowids 0..9 through random handshaking.
    popped.delete();
    next_fid = 0;
    for (int c = 0; c < 2000; c++) begin
      if (next_fid == 10 && model_q.size() == 0) break;
      step((next_fid < 10) && ($urandom_range(0, 1) == 1), next_fid, $urandom_range(0, 1) == 1, acc);
      if (acc) next_fid++;
    end
    check("wrap_count", 128'(popped.size()), 128'(10));
    for (int i = 0; i < 10; i++) begin
      check("wrap_order", 128'(i < popped.size() ? popped[i] : -1), 128'(i));
    end

    // Random traffic with frequent flowid collisions.
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 5), $urandom_range(0, 2) == 0, acc);
    end
    repeat (DEPTH + 1) step(1'b0, 0, 1'b1, acc);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
